// File: rtl/mask_if.sv
// Bundles the data word, the keep-count and the registered masked result
// of the mask block. The master drives data and position; the slave returns
// the masked word.
interface mask_if #(
  parameter int WIDTH = 15,
  parameter int POS_W = 7
);

  logic [WIDTH-1:0] Maskin;
  logic [POS_W-1:0] position;
  logic [WIDTH-1:0] Maskout;

  modport master (
    output Maskin,
    output position,
    input  Maskout
  );

  modport slave (
    input  Maskin,
    input  position,
    output Maskout
  );

endinterface : mask_if

// File: rtl/mask.sv
// Low-order bit keeper: Maskout is loaded every clock with Maskin ANDed with
// a mask of min(position, WIDTH) ones starting at bit 0. Any position at or
// above WIDTH saturates to a full pass-through; nothing wraps.
// The mask is pure combinational logic of position, followed by the single
// output register, which clears asynchronously while rst is low.
module mask #(
  parameter int WIDTH = 15,
  parameter int POS_W = 7
) (
  input  logic  clk,
  input  logic  rst,
  mask_if.slave bus
);

  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] masked_next;
  logic [WIDTH-1:0] maskout_reg;

  // Position widened to 32 bits so the per-bit compare stays correct even
  // when WIDTH exceeds the range position can express.
  logic [31:0] position_ext;

  assign position_ext = 32'(bus.position);

  // Bit gi is kept exactly when gi < k, which is equivalent to position > gi;
  // positions beyond WIDTH therefore light every bit without any modulo.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mask_bit
      localparam int unsigned BIT_IDX = gi;
      assign mask_next[gi]   = (position_ext > BIT_IDX);
      assign masked_next[gi] = bus.Maskin[gi] & mask_next[gi];
    end
  endgenerate

  // Output register: cleared at once on reset, otherwise reloaded every edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      maskout_reg <= '0;
    end else begin
      maskout_reg <= masked_next;
    end
  end

  assign bus.Maskout = maskout_reg;

endmodule : mask

// File: tb/tb_mask.sv
// Directed bench for the mask block: reset behaviour, saturation, partial and
// zero masks, one-cycle latency and a full position sweep.
module tb_mask;

  localparam int WIDTH = 15;
  localparam int POS_W = 7;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  mask_if #(.WIDTH(WIDTH), .POS_W(POS_W)) bus ();

  mask #(.WIDTH(WIDTH), .POS_W(POS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end else begin
      $display("ok   %s: %b", tag, obs);
    end
  endtask

  // Drive inputs on the falling edge, check just after the next rising edge.
  task automatic apply(input string tag, input logic [WIDTH-1:0] din,
                       input logic [POS_W-1:0] pos, input logic [WIDTH-1:0] exp);
    @(negedge clk);
    bus.Maskin   = din;
    bus.position = pos;
    @(posedge clk);
    #1;
    chk(tag, bus.Maskout, exp);
  endtask

  // Reference mask built from a shift rather than a per-bit compare.
  function automatic logic [WIDTH-1:0] ref_mask(input int unsigned pos);
    logic [WIDTH-1:0] one;
    one = 1;
    if (pos >= WIDTH) return '1;
    return (one << pos) - one;
  endfunction

  logic [WIDTH-1:0] lat_vals [6];
  logic [WIDTH-1:0] rnd;

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b0;
    bus.Maskin   = '1;
    bus.position = 7'd15;

    // Reset held for two cycles with live inputs: output stays clear.
    #1;
    chk("reset_initial", bus.Maskout, 15'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("reset_hold%0d", i), bus.Maskout, 15'b0);
    end

    // Release between edges; first load happens on the next rising edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_release_noedge", bus.Maskout, 15'b0);
    @(posedge clk);
    #1;
    chk("first_load", bus.Maskout, 15'b111111111111111);

    // Saturated pass-through.
    apply("sat_pos24", 15'b111101111011110, 7'd24, 15'b111101111011110);
    apply("sat_pos56", 15'b100101001011110, 7'd56, 15'b100101001011110);
    apply("sat_pos47", 15'b111111111011110, 7'd47, 15'b111111111011110);
    apply("sat_pos127", 15'b010101010101011, 7'd127, 15'b010101010101011);

    // Partial masks.
    apply("part_pos5", 15'b111111111111111, 7'd5, 15'b000000000011111);
    apply("part_pos14", 15'b111111111111111, 7'd14, 15'b011111111111111);
    apply("part_pos15", 15'b111111111111111, 7'd15, 15'b111111111111111);
    apply("part_pos1", 15'b101010101010101, 7'd1, 15'b000000000000001);
    apply("part_pos8", 15'b110011001100110, 7'd8, 15'b000000001100110);
    apply("part_pos16", 15'b100000000000001, 7'd16, 15'b100000000000001);

    // Zero mask.
    apply("zero_pos0", 15'b101010101010101, 7'd0, 15'b000000000000000);

    // Latency: new word every cycle, each visible exactly one edge later
    // and still held just before the following edge.
    lat_vals[0] = 15'h1234;
    lat_vals[1] = 15'h7fff;
    lat_vals[2] = 15'h0001;
    lat_vals[3] = 15'h5a5a;
    lat_vals[4] = 15'h2c3d;
    lat_vals[5] = 15'h0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) chk($sformatf("lat_hold%0d", i - 1), bus.Maskout, lat_vals[i-1]);
      bus.Maskin   = lat_vals[i];
      bus.position = 7'd15;
      @(posedge clk);
      #1;
      chk($sformatf("lat_load%0d", i), bus.Maskout, lat_vals[i]);
    end

    // Asynchronous reset mid-operation, away from any clock edge.
    apply("pre_async", 15'b011011011011011, 7'd127, 15'b011011011011011);
    #2;
    rst = 1'b0;
    #1;
    chk("async_clear", bus.Maskout, 15'b0);
    @(posedge clk);
    #1;
    chk("async_hold", bus.Maskout, 15'b0);
    @(negedge clk);
    rst = 1'b1;

    // Sweep every position against a random word.
    for (int p = 0; p < 128; p++) begin
      rnd = WIDTH'($urandom);
      apply($sformatf("sweep_pos%0d", p), rnd, POS_W'(p), rnd & ref_mask(p));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_mask
